// File: rtl/text_pkg.sv
// Shared constants, control codes and writer state encoding for the 80x25 text frame store.
package text_pkg;

   localparam int COLS  = 80;
   localparam int ROWS  = 25;
   localparam int CELLS = COLS * ROWS;

   localparam logic [7:0] BLANK = 8'h20;
   localparam logic [7:0] CC_CR = 8'h0D;
   localparam logic [7:0] CC_LF = 8'h0A;
   localparam logic [7:0] CC_BS = 8'h08;
   localparam logic [7:0] CC_FF = 8'h0C;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCROLL_RD,
      ST_SCROLL_WR,
      ST_CLEAR_ROW,
      ST_CLEAR_ALL
   } wr_state_e;

endpackage

// File: rtl/char_ram.sv
// 2^AW x 8 simple dual-port character RAM: port A is the display read, port B the writer's read/write.
module char_ram #(
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] a_addr_i,
   output logic [7:0]    a_data_o,
   input  logic [AW-1:0] b_addr_i,
   input  logic          b_we_i,
   input  logic [7:0]    b_wdata_i,
   output logic [7:0]    b_rdata_o
);
   import text_pkg::*;

   logic [7:0] mem [0:(1<<AW)-1];
   logic [7:0] a_data_q;
   logic [7:0] b_rdata_q;

   always_ff @(posedge clk) begin
      if (b_we_i) begin
         mem[b_addr_i] <= b_wdata_i;
      end else begin
         b_rdata_q <= mem[b_addr_i];
      end
   end

   // Only the output register is reset, so the display shows blanks before the first clear lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_data_q <= BLANK;
      end else begin
         a_data_q <= mem[a_addr_i];
      end
   end

   assign a_data_o  = a_data_q;
   assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/text_buffer.sv
// Text frame store and terminal writer; optional inverse-video cursor under TEXT_BUFFER_CURSOR_EN.
// state      | meaning
// IDLE       | accepting bytes, printable bytes written at the cursor
// SCROLL_RD  | read cell idx+COLS on port B
// SCROLL_WR  | write that data to cell idx
// CLEAR_ROW  | blank the bottom row after a scroll
// CLEAR_ALL  | blank the whole screen (reset, form feed)
module text_buffer #(
   parameter int COLS = text_pkg::COLS,
   parameter int ROWS = text_pkg::ROWS,
   parameter int AW   = 11
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] pos,
   output logic [7:0]    char,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          busy
);
   import text_pkg::*;

   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);

   localparam logic [CW-1:0] COL_LAST      = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST      = RW'(ROWS - 1);
   localparam logic [AW-1:0] COLS_A        = AW'(COLS);
   localparam logic [AW-1:0] LAST_ROW_BASE = AW'(COLS * (ROWS - 1));
   localparam logic [AW-1:0] SCROLL_LAST   = AW'(COLS * (ROWS - 1) - 1);
   localparam logic [AW-1:0] CELL_LAST     = AW'(COLS * ROWS - 1);

   wr_state_e      state_q;
   logic [CW-1:0]  col_q;
   logic [RW-1:0]  row_q;
   logic [AW-1:0]  cur_q;
   logic [AW-1:0]  idx_q;

   logic           accept;
   logic           printable;
   logic           ram_we;
   logic [AW-1:0]  ram_addr;
   logic [7:0]     ram_wdata;
   logic [7:0]     ram_rdata;
   logic [7:0]     ram_a_data;

   assign accept    = in_valid && (state_q == ST_IDLE);
   assign printable = (in_data[7:5] != 3'b000);

   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = idx_q;
      ram_wdata = BLANK;
      case (state_q)
         ST_IDLE: begin
            ram_addr  = cur_q;
            ram_wdata = in_data;
            ram_we    = accept && printable;
         end
         ST_SCROLL_RD: ram_addr = idx_q + COLS_A;
         ST_SCROLL_WR: begin
            ram_we    = 1'b1;
            ram_wdata = ram_rdata;
         end
         ST_CLEAR_ROW, ST_CLEAR_ALL: ram_we = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR_ALL;
         col_q   <= '0;
         row_q   <= '0;
         cur_q   <= '0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (printable) begin
                     if (col_q == COL_LAST) begin
                        // Wrap: cur+1 already lands on the next row start; at the bottom it scrolls.
                        col_q <= '0;
                        if (row_q != ROW_LAST) begin
                           row_q <= row_q + 1'b1;
                           cur_q <= cur_q + 1'b1;
                        end else begin
                           cur_q   <= LAST_ROW_BASE;
                           idx_q   <= '0;
                           state_q <= ST_SCROLL_RD;
                        end
                     end else begin
                        col_q <= col_q + 1'b1;
                        cur_q <= cur_q + 1'b1;
                     end
                  end else begin
                     case (in_data)
                        CC_CR: begin
                           col_q <= '0;
                           cur_q <= cur_q - AW'(col_q);
                        end
                        CC_LF: begin
                           if (row_q != ROW_LAST) begin
                              row_q <= row_q + 1'b1;
                              cur_q <= cur_q + COLS_A;
                           end else begin
                              idx_q   <= '0;
                              state_q <= ST_SCROLL_RD;
                           end
                        end
                        CC_BS: begin
                           if (col_q != '0) begin
                              col_q <= col_q - 1'b1;
                              cur_q <= cur_q - 1'b1;
                           end
                        end
                        CC_FF: begin
                           col_q   <= '0;
                           row_q   <= '0;
                           cur_q   <= '0;
                           idx_q   <= '0;
                           state_q <= ST_CLEAR_ALL;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            ST_SCROLL_RD: state_q <= ST_SCROLL_WR;
            ST_SCROLL_WR: begin
               if (idx_q == SCROLL_LAST) begin
                  idx_q   <= LAST_ROW_BASE;
                  state_q <= ST_CLEAR_ROW;
               end else begin
                  idx_q   <= idx_q + 1'b1;
                  state_q <= ST_SCROLL_RD;
               end
            end
            ST_CLEAR_ROW, ST_CLEAR_ALL: begin
               if (idx_q == CELL_LAST) begin
                  state_q <= ST_IDLE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: state_q <= ST_CLEAR_ALL;
         endcase
      end
   end

   assign in_ready = (state_q == ST_IDLE);
   assign busy     = ~in_ready;

   char_ram #(.AW(AW)) u_ram (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_addr_i  (pos),
      .a_data_o  (ram_a_data),
      .b_addr_i  (ram_addr),
      .b_we_i    (ram_we),
      .b_wdata_i (ram_wdata),
      .b_rdata_o (ram_rdata)
   );

`ifdef TEXT_BUFFER_CURSOR_EN
   logic cur_hit_q;

   // Compare is registered alongside the RAM read so the flag lines up with its data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_hit_q <= 1'b0;
      end else begin
         cur_hit_q <= (pos == cur_q) && (state_q == ST_IDLE);
      end
   end

   assign char = ram_a_data ^ {cur_hit_q, 7'b0};
`else
   assign char = ram_a_data;
`endif

endmodule

// File: tb/tb_text_buffer.sv
// Scoreboard bench for text_buffer: screen/cursor model in plain arrays, randomized byte stream.
module tb_text_buffer;
   localparam int COLS        = 80;
   localparam int ROWS        = 25;
   localparam int AW          = 11;
   localparam int CELLS       = COLS * ROWS;
   localparam int SCROLL_CLKS = 2 * COLS * (ROWS - 1) + COLS;
   localparam int CLEAR_CLKS  = CELLS;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] pos = '0;
   logic [7:0]    char_o;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          busy;

   text_buffer #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pos      (pos),
      .char     (char_o),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   byte unsigned m_mem [CELLS];
   int           m_col = 0;
   int           m_row = 0;

   logic [7:0] exp_q [$];
   int         addr_q [$];
   logic       rd_req = 1'b0;
   logic       rd_vld = 1'b0;

   always @(posedge clk) rd_vld <= rd_req;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: every registered read result is matched against the queued expectation.
   always @(negedge clk) begin : monitor
      logic [7:0] e;
      int         a;
      if (rd_vld) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL cell_unexpected: got %0h want no read", char_o);
         end else begin
            e = exp_q.pop_front();
            a = addr_q.pop_front();
            if (char_o !== e) begin
               errors++;
               $display("FAIL cell[%0d]: got %0h want %0h", a, char_o, e);
            end
         end
      end
   end

   function automatic void model_blank();
      for (int i = 0; i < CELLS; i++) m_mem[i] = 8'h20;
   endfunction

   function automatic int model_lf();
      if (m_row < ROWS - 1) begin
         m_row++;
         return 0;
      end
      for (int i = 0; i < CELLS - COLS; i++) m_mem[i] = m_mem[i + COLS];
      for (int i = CELLS - COLS; i < CELLS; i++) m_mem[i] = 8'h20;
      return SCROLL_CLKS;
   endfunction

   // Applies one byte to the model; returns the number of busy clocks it should cause.
   function automatic int model_byte(input logic [7:0] b);
      int l;
      l = 0;
      if (b == 8'h0D) m_col = 0;
      else if (b == 8'h0A) l = model_lf();
      else if (b == 8'h08) begin
         if (m_col > 0) m_col--;
      end else if (b == 8'h0C) begin
         m_col = 0;
         m_row = 0;
         model_blank();
         l = CLEAR_CLKS;
      end else if (b >= 8'h20) begin
         m_mem[m_row * COLS + m_col] = b;
         m_col++;
         if (m_col == COLS) begin
            m_col = 0;
            l = model_lf();
         end
      end
      return l;
   endfunction

   function automatic logic [7:0] exp_cell(input int a);
      logic [7:0] v;
      v = m_mem[a];
`ifdef TEXT_BUFFER_CURSOR_EN
      if (a == m_row * COLS + m_col) v = v ^ 8'h80;
`endif
      return v;
   endfunction

   task automatic rd(input int a);
      pos    = AW'(a);
      rd_req = 1'b1;
      exp_q.push_back(exp_cell(a));
      addr_q.push_back(a);
      @(negedge clk);
      rd_req = 1'b0;
   endtask

   task automatic dump();
      for (int a = 0; a < CELLS; a++) rd(a);
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      int l;
      int n;
      n = 0;
      while (!in_ready && n < 10000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
      in_data  = b;
      in_valid = 1'b1;
      l = model_byte(b);
      @(negedge clk);
      if (l > 0) begin
         in_data = 8'h5A;
         n = 0;
         while (!in_ready && n < l + 100) begin
            n++;
            @(negedge clk);
         end
         chk("busy_len", n, l);
      end else begin
         chk("ready_next", in_ready, 1'b1);
      end
      in_valid = 1'b0;
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      int r;
      logic [7:0] b;
      model_blank();
      repeat (3) @(negedge clk);
      chk("rst_ready", in_ready, 1'b0);
      chk("rst_busy", busy, 1'b1);
      chk("rst_char", char_o, 8'h20);

      rst_n = 1'b1;
      n = 0;
      while (!in_ready && n < 5000) begin
         n++;
         @(negedge clk);
      end
      chk("reset_clear_len", n, CLEAR_CLKS);
      rd(0); rd(1000); rd(1999);

      send("A"); send("B"); send(8'h0D); send("C");
      rd(0); rd(1); rd(2);

      send(8'h0C);
      repeat (COLS) send(8'h41);
      for (int a = 0; a <= COLS; a++) rd(a);
      send("Q");
      rd(80); rd(81);

      send(8'h0C);
      for (int row = 0; row < ROWS; row++) begin
         for (int c = 0; c < ((row == ROWS - 1) ? COLS - 1 : COLS); c++) send(8'h30 + 8'(row % 10));
      end
      send(8'h0A);
      dump();

      send(8'h0C);
      send(8'h08);
      rd(0);
      send("X"); send(8'h08); send("Y");
      rd(0); rd(1);

      send(8'h0C);
      repeat (6) send(8'h41);
      send(8'h08);
      rd(4); rd(5); rd(6);

      for (int k = 0; k < 250; k++) begin
         r = $urandom_range(0, 99);
         if (r < 8) b = 8'h0A;
         else if (r < 12) b = 8'h0D;
         else if (r < 16) b = 8'h08;
         else if (r < 18) b = 8'($urandom_range(0, 31));
         else if (r < 19) b = 8'h0C;
         else b = 8'($urandom_range(32, 255));
         send(b);
         if (k == 125) dump();
      end
      dump();

      // Reset in the middle of a clear must restart it from cell 0 for the full length.
      in_data  = 8'h0C;
      in_valid = 1'b1;
      void'(model_byte(8'h0C));
      @(negedge clk);
      in_valid = 1'b0;
      repeat (500) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_ready", in_ready, 1'b0);
      chk("midrst_char", char_o, 8'h20);
      rst_n = 1'b1;
      m_col = 0;
      m_row = 0;
      model_blank();
      n = 0;
      while (!in_ready && n < 5000) begin
         n++;
         @(negedge clk);
      end
      chk("midrst_clear_len", n, CLEAR_CLKS);
      send("Z");
      rd(0); rd(1); rd(1999);

      @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
